// File: rtl/btn_event_gen.sv
// btn_event_gen
//   Button front end for the calculator: per-button 2-flop synchroniser,
//   debounce filter, press/release edge pulses and optional auto-repeat.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_btn        raw button pins, active-low, asynchronous to i_clk
//   i_repeat_en  global auto-repeat enable
//   o_pressed    debounced level, 1 = held
//   o_event      one-cycle pulse on each accepted press and each auto-repeat
//   o_release    one-cycle pulse on each accepted release
module btn_event_gen #(
  parameter int unsigned    N               = 11,
  parameter int unsigned    DEBOUNCE_CYCLES = 250000,
  parameter int unsigned    REPEAT_DELAY    = 6000000,
  parameter int unsigned    REPEAT_RATE     = 1500000,
  parameter logic [N-1:0]   REPEAT_MASK     = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_btn,
  input  logic          i_repeat_en,
  output logic [N-1:0]  o_pressed,
  output logic [N-1:0]  o_event,
  output logic [N-1:0]  o_release
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RP_W-1:0] RP_DELAY = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_RATE  = RP_W'(REPEAT_RATE);

  // Repeat phase: waiting for the initial delay, or in the steady repeat rate.
  typedef enum logic {
    PH_DELAY = 1'b0,
    PH_RATE  = 1'b1
  } phase_t;

  logic [N-1:0]    sync1, sync2;
  logic [N-1:0]    stable, stable_nxt;
  logic [N-1:0]    fall, rise, fire;
  logic [DB_W-1:0] db_cnt     [N];
  logic [DB_W-1:0] db_cnt_nxt [N];
  logic [RP_W-1:0] rp_cnt     [N];
  logic [RP_W-1:0] rp_cnt_nxt [N];
  phase_t          phase      [N];
  phase_t          phase_nxt  [N];

  assign o_pressed = ~stable;

  always_comb begin
    logic [DB_W-1:0] db_inc;
    logic [RP_W-1:0] rp_inc;
    logic [RP_W-1:0] rp_target;
    stable_nxt = stable;
    fall       = '0;
    rise       = '0;
    fire       = '0;
    db_inc     = '0;
    rp_inc     = '0;
    rp_target  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // Debounce: accept the new level on the edge the count would hit the limit.
      db_cnt_nxt[i] = '0;
      db_inc        = db_cnt[i] + 1'b1;
      if (sync2[i] != stable[i]) begin
        if (db_inc == DB_LAST) begin
          stable_nxt[i] = sync2[i];
        end else begin
          db_cnt_nxt[i] = db_inc;
        end
      end
      fall[i] = stable[i] & ~stable_nxt[i];
      rise[i] = ~stable[i] & stable_nxt[i];

      // Auto-repeat runs only while held before and after this edge; a press
      // edge (stable was 1) and a release edge both land in the cleared branch,
      // so a release coinciding with a repeat suppresses the repeat.
      rp_cnt_nxt[i] = '0;
      phase_nxt[i]  = PH_DELAY;
      rp_inc        = rp_cnt[i] + 1'b1;
      rp_target     = (phase[i] == PH_RATE) ? RP_RATE : RP_DELAY;
      if (REPEAT_MASK[i] && i_repeat_en && !stable[i] && !rise[i]) begin
        if (rp_inc == rp_target) begin
          fire[i]      = 1'b1;
          phase_nxt[i] = PH_RATE;
        end else begin
          rp_cnt_nxt[i] = rp_inc;
          phase_nxt[i]  = phase[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1     <= '1;
      sync2     <= '1;
      stable    <= '1;
      o_event   <= '0;
      o_release <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        db_cnt[i] <= '0;
        rp_cnt[i] <= '0;
        phase[i]  <= PH_DELAY;
      end
    end else begin
      sync1     <= i_btn;
      sync2     <= sync1;
      stable    <= stable_nxt;
      o_event   <= fall | fire;
      o_release <= rise;
      for (int unsigned i = 0; i < N; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
        rp_cnt[i] <= rp_cnt_nxt[i];
        phase[i]  <= phase_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
module tb_btn_event_gen;

  localparam int unsigned NB = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;
  localparam logic [NB-1:0] RMASK = 4'b0011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn;
  logic          rep_en;
  logic [NB-1:0] pressed, event_o, release_o;

  btn_event_gen #(
    .N               (NB),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .REPEAT_MASK     (RMASK)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn       (btn),
    .i_repeat_en (rep_en),
    .o_pressed   (pressed),
    .o_event     (event_o),
    .o_release   (release_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   cyc;
    logic [NB-1:0] ev;
    logic [NB-1:0] rel;
  } exp_t;

  typedef struct {
    logic [NB-1:0]      mask;
    int unsigned        hold;
    logic [NB-1:0][7:0] exp_ev;
  } vec_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned ev_count  [NB];
  int unsigned rel_count [NB];

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %b required %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int unsigned c, input logic [NB-1:0] ev, input logic [NB-1:0] rel);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    e.rel = rel;
    sb_q.push_back(e);
  endtask

  // One clock: wait for the falling edge, then compare the pulse outputs of
  // the preceding rising edge with whatever the scoreboard expects for it.
  task automatic tick();
    logic [NB-1:0] exp_ev, exp_rel;
    @(negedge clk);
    cyc++;
    exp_ev  = '0;
    exp_rel = '0;
    for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        exp_ev  |= sb_q[i].ev;
        exp_rel |= sb_q[i].rel;
        sb_q.delete(i);
      end
    end
    chk("event", event_o, exp_ev);
    chk("release", release_o, exp_rel);
    for (int b = 0; b < int'(NB); b++) begin
      if (event_o[b])   ev_count[b]++;
      if (release_o[b]) rel_count[b]++;
    end
  endtask

  // Expected pulses for bits held from press edge e to release edge r with
  // auto-repeat enabled throughout.
  task automatic push_hold(input logic [NB-1:0] mask, input int unsigned e, input int unsigned r);
    int unsigned t;
    for (int b = 0; b < int'(NB); b++) begin
      if (mask[b]) begin
        push(e, NB'(1) << b, '0);
        push(r, '0, NB'(1) << b);
        if (RMASK[b]) begin
          t = e + RD;
          while (t < r) begin
            push(t, NB'(1) << b, '0);
            t += RR;
          end
        end
      end
    end
  endtask

  function automatic vec_t mk(input logic [NB-1:0] mask, input int unsigned hold,
                              input int unsigned e3, input int unsigned e2,
                              input int unsigned e1, input int unsigned e0);
    vec_t v;
    v.mask      = mask;
    v.hold      = hold;
    v.exp_ev[3] = 8'(e3);
    v.exp_ev[2] = 8'(e2);
    v.exp_ev[1] = 8'(e1);
    v.exp_ev[0] = 8'(e0);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    int unsigned c0, e, r, cr;
    int unsigned ev_base [NB];
    int unsigned rel_base [NB];

    for (int b = 0; b < int'(NB); b++) begin
      ev_count[b]  = 0;
      rel_count[b] = 0;
    end

    // Press length is measured from press edge to release edge.
    vecs[0] = mk(4'b0100, 30, 0, 1, 0, 0);   // clean press, no repeat on bit 2
    vecs[1] = mk(4'b0001, 40, 0, 0, 0, 11);  // repeats at +10,+13..+37
    vecs[2] = mk(4'b1111, 15, 1, 1, 3, 3);   // simultaneous, repeats bits 0-1
    vecs[3] = mk(4'b0010, 10, 0, 0, 1, 0);   // release coincides with first repeat
    vecs[4] = mk(4'b1000,  6, 1, 0, 0, 0);   // shortest hold
    vecs[5] = mk(4'b0001, 11, 0, 0, 0, 2);   // one repeat just before release

    rst_n  = 1'b0;
    btn    = '1;
    rep_en = 1'b1;
    repeat (3) tick();
    chk("reset pressed", pressed, '0);
    chk("reset event", event_o, '0);
    chk("reset release", release_o, '0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Table-driven press/release vectors.
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < int'(NB); b++) begin
        ev_base[b]  = ev_count[b];
        rel_base[b] = rel_count[b];
      end
      c0 = cyc;
      e  = c0 + 2 + DB;
      r  = e + vecs[v].hold;
      push_hold(vecs[v].mask, e, r);
      btn = ~vecs[v].mask;
      repeat (DB + 2) tick();
      chk("pressed during hold", pressed, vecs[v].mask);
      repeat (vecs[v].hold - (DB + 2)) tick();
      btn = '1;
      repeat (DB + 10) tick();
      chk("pressed after release", pressed, '0);
      for (int b = 0; b < int'(NB); b++) begin
        chk_int($sformatf("vec%0d event count bit%0d", v, b), ev_count[b] - ev_base[b],
                int'(vecs[v].exp_ev[b]));
        chk_int($sformatf("vec%0d release count bit%0d", v, b), rel_count[b] - rel_base[b],
                int'(vecs[v].mask[b]));
      end
    end

    // Bounce: low 3 / high 1, four times, must never be accepted.
    for (int n = 0; n < 4; n++) begin
      btn[3] = 1'b0;
      repeat (3) tick();
      chk("bounce pressed", pressed, '0);
      btn[3] = 1'b1;
      tick();
      chk("bounce pressed", pressed, '0);
    end
    c0 = cyc;
    btn[3] = 1'b0;
    push(c0 + 6, 4'b1000, '0);
    repeat (8) tick();
    chk("bounce settled pressed", pressed, 4'b1000);
    btn[3] = 1'b1;
    push(c0 + 8 + 6, '0, 4'b1000);
    repeat (14) tick();

    // Repeat gating on bit 1: enable dropped after E+12, restored after E+20.
    c0 = cyc;
    e  = c0 + 2 + DB;
    btn[1] = 1'b0;
    push(e, 4'b0010, '0);
    push(e + 10, 4'b0010, '0);
    for (int unsigned t = e + 30; t < e + 45; t += RR) push(t, 4'b0010, '0);
    push(e + 45, '0, 4'b0010);
    repeat (18) tick();
    rep_en = 1'b0;
    repeat (8) tick();
    rep_en = 1'b1;
    repeat (19) tick();
    btn[1] = 1'b1;
    repeat (14) tick();

    // Reset while bit 0 is held; the hold is seen as a fresh press afterwards.
    c0 = cyc;
    e  = c0 + 2 + DB;
    btn[0] = 1'b0;
    push(e, 4'b0001, '0);
    repeat (6) tick();
    chk("pre-reset pressed", pressed, 4'b0001);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("async reset pressed", pressed, '0);
    chk("async reset event", event_o, '0);
    chk("async reset release", release_o, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    cr = cyc;
    push(cr + 6, 4'b0001, '0);
    repeat (8) tick();
    chk("post-reset pressed", pressed, 4'b0001);
    btn[0] = 1'b1;
    push(cr + 14, '0, 4'b0001);
    repeat (14) tick();

    chk_int("scoreboard drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
